issue_fifo: RTL and testbench
=============================

ISSUE_FIFO -- requirements
Module: issue_fifo

Interface
REQ-001 SHALL have parameter WAYS, default 3, meaning lanes pushed/popped per cycle.
REQ-002 SHALL have parameter DEPTH, default 8, meaning entry count (power of two, >= WAYS).
REQ-003 SHALL have parameter PRF, default 64, meaning physical register count; ROB, default 16, meaning ROB entry count.
REQ-004 SHALL have port clock  input  1  clock; reset reset, synchronous, active-high; clock clock.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port flush  input  1  squash all entries (mispredict recovery).
REQ-007 SHALL have port in_valid  input  WAYS  issued-instruction valid from the reservation station, LSB-contiguous (001, 011, 111).
REQ-008 SHALL have port in_packet  input  WAYS x ID_EX_PACKET  issued instructions with operand values resolved.
REQ-009 SHALL have port in_dest_prf  input  WAYS x clog2(PRF)  destination physical register; in_rob_idx  input  WAYS x clog2(ROB)  ROB tag.
REQ-010 SHALL have port out_valid  output  WAYS  lane i holds entry head+i.
REQ-011 SHALL have port out_packet / out_dest_prf / out_rob_idx  output  same widths as inputs  head-ordered entries.
REQ-012 SHALL have port out_ready  input  WAYS  functional-unit accept per lane.
REQ-013 SHALL have port num_free  output  clog2(DEPTH)+1  free slots, registered.
REQ-014 SHALL have port almost_full  output  1  num_free < WAYS.
REQ-015 SHALL have port overflow  output  1  sticky: a push was dropped.

Function
REQ-016 SHALL store entries in a DEPTH-slot circular buffer with head, tail (clog2(DEPTH) bits, wrap modulo DEPTH) and count (0..DEPTH).
REQ-017 push_n SHALL equal popcount(in_valid); lane i written at tail+i in lane order.
REQ-018 Accepted pushes SHALL be limited to num_free as registered at cycle start; lanes beyond that SHALL be dropped and overflow set next cycle.
REQ-019 out_valid[i] SHALL equal (count > i); out data SHALL come from slot (head+i) mod DEPTH; no same-cycle bypass (push-to-output latency 1 cycle).
REQ-020 pop_n SHALL equal the number of consecutive lanes from lane 0 with out_valid & out_ready; a ready lane after a non-ready lane SHALL NOT pop.
REQ-021 Next state: head += pop_n, tail += accepted push_n, count = count - pop_n + accepted push_n, all modulo wrap.
REQ-022 Simultaneous push and pop SHALL both take effect; freed slots become pushable the following cycle only.
REQ-023 flush SHALL zero head, tail, count at the clock edge, overriding pushes and pops that cycle; overflow unaffected.
REQ-024 Order SHALL be strict FIFO across lanes and wrap-around.

Reset
REQ-025 On reset: head=0, tail=0, count=0, out_valid=0, num_free=DEPTH, almost_full=0, overflow=0; reset overrides flush, push and pop.
REQ-026 Slot payload storage SHALL NOT require reset.

Structure
REQ-027 ID_EX_PACKET, WAYS, PRF, ROB SHALL come from the shared system-defines package; no new typedefs local to the module.
REQ-028 One sub-module SHALL be natural: issue_fifo_ctrl (pointer/count arithmetic, pop_n and accepted push_n); storage stays in issue_fifo.

Verification
REQ-029 Reset, in_valid=111 then idle -> next cycle out_valid=111, num_free=5, order matches lanes 0,1,2.
REQ-030 Fill to 8 (111,111,011), out_ready=000 -> num_free=0, almost_full=1; push 001 -> dropped, overflow=1, contents unchanged.
REQ-031 count=4, out_ready=101 -> pop_n=1, count=3, head advances by 1.
REQ-032 head=6, count=2, push 111, out_ready=111 -> pop 2, count=3, entries at slots 0..2 after wrap, FIFO order preserved.
REQ-033 count=5, push 011 and flush same cycle -> count=0, out_valid=000, num_free=8.
REQ-034 Mid-operation reset with count=6, overflow=1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/issue_fifo_pkg.sv
// Shared system defines for the issue path: machine widths and the ID/EX
// packet that travels from the reservation station to the functional units.
package issue_fifo_pkg;

    localparam int WAYS  = 3;
    localparam int DEPTH = 8;
    localparam int PRF   = 64;
    localparam int ROB   = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
    } id_ex_packet_t;

endpackage

// File: rtl/issue_fifo_if.sv
// Issue-queue lane bundle: reservation-station pushes in, head-ordered entries
// out to the functional units, plus occupancy status.
interface issue_fifo_if
    import issue_fifo_pkg::*;
#(
    parameter int WAYS  = issue_fifo_pkg::WAYS,
    parameter int DEPTH = issue_fifo_pkg::DEPTH,
    parameter int PRF   = issue_fifo_pkg::PRF,
    parameter int ROB   = issue_fifo_pkg::ROB
);
    localparam int PRF_W = $clog2(PRF);
    localparam int ROB_W = $clog2(ROB);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic          [WAYS-1:0]             in_valid;
    id_ex_packet_t [WAYS-1:0]             in_packet;
    logic          [WAYS-1:0][PRF_W-1:0]  in_dest_prf;
    logic          [WAYS-1:0][ROB_W-1:0]  in_rob_idx;

    logic          [WAYS-1:0]             out_valid;
    id_ex_packet_t [WAYS-1:0]             out_packet;
    logic          [WAYS-1:0][PRF_W-1:0]  out_dest_prf;
    logic          [WAYS-1:0][ROB_W-1:0]  out_rob_idx;
    logic          [WAYS-1:0]             out_ready;

    logic          [CNT_W-1:0]            num_free;
    logic                                 almost_full;
    logic                                 overflow;

    modport master (
        output in_valid, in_packet, in_dest_prf, in_rob_idx, out_ready,
        input  out_valid, out_packet, out_dest_prf, out_rob_idx,
        input  num_free, almost_full, overflow
    );

    modport slave (
        input  in_valid, in_packet, in_dest_prf, in_rob_idx, out_ready,
        output out_valid, out_packet, out_dest_prf, out_rob_idx,
        output num_free, almost_full, overflow
    );

endinterface

// File: rtl/issue_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for the issue FIFO: decides how many lanes
// are accepted and how many pop this cycle, and keeps head/tail/count/overflow.
module issue_fifo_ctrl #(
    parameter  int WAYS  = 3,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WAYS-1:0]  in_valid,
    input  logic [WAYS-1:0]  out_ready,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] push_n,
    output logic [WAYS-1:0]  out_valid,
    output logic [CNT_W-1:0] num_free,
    output logic             almost_full,
    output logic             overflow
);
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] num_free_q, num_free_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] req_n;
    logic [CNT_W-1:0] pop_n;
    logic             pop_run;

    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        out_valid = '0;
        pop_n     = '0;
        pop_run   = 1'b1;

        // Capacity is judged against the free count at cycle start; slots freed
        // by this cycle's pops only become pushable next cycle.
        req_n  = CNT_W'($countones(in_valid));
        push_n = (req_n > num_free_q) ? num_free_q : req_n;

        for (int i = 0; i < WAYS; i++) begin
            out_valid[i] = count_q > CNT_W'(i);
            if (pop_run && out_valid[i] && out_ready[i]) begin
                pop_n = pop_n + CNT_W'(1);
            end else begin
                pop_run = 1'b0;
            end
        end

        head_d     = head_q + PTR_W'(pop_n);
        tail_d     = tail_q + PTR_W'(push_n);
        count_d    = count_q - pop_n + push_n;
        overflow_d = overflow_q | (req_n > num_free_q);

        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = overflow_q;
        end

        num_free_d = CNT_W'(DEPTH) - count_d;
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            num_free_q <= CNT_W'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            num_free_q <= num_free_d;
            overflow_q <= overflow_d;
        end
    end

    assign head        = head_q;
    assign tail        = tail_q;
    assign num_free    = num_free_q;
    assign almost_full = num_free_q < CNT_W'(WAYS);
    assign overflow    = overflow_q;

endmodule

// File: rtl/issue_fifo.sv
// Multi-lane issue FIFO between the reservation station and the functional
// units: WAYS pushes and WAYS in-order pops per cycle over a circular buffer.
module issue_fifo
    import issue_fifo_pkg::*;
#(
    parameter int WAYS  = issue_fifo_pkg::WAYS,
    parameter int DEPTH = issue_fifo_pkg::DEPTH,
    parameter int PRF   = issue_fifo_pkg::PRF,
    parameter int ROB   = issue_fifo_pkg::ROB
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    issue_fifo_if.slave io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PRF_W = $clog2(PRF);
    localparam int ROB_W = $clog2(ROB);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] push_n;

    issue_fifo_ctrl #(
        .WAYS  (WAYS),
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (io.in_valid),
        .out_ready   (io.out_ready),
        .head        (head),
        .tail        (tail),
        .push_n      (push_n),
        .out_valid   (io.out_valid),
        .num_free    (io.num_free),
        .almost_full (io.almost_full),
        .overflow    (io.overflow)
    );

    id_ex_packet_t    pkt_mem_q [DEPTH];
    logic [PRF_W-1:0] prf_mem_q [DEPTH];
    logic [ROB_W-1:0] rob_mem_q [DEPTH];

    logic [WAYS-1:0]            wr_en;
    logic [WAYS-1:0][PTR_W-1:0] wr_idx;

    always_comb begin
        wr_en  = '0;
        wr_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            wr_idx[i] = tail + PTR_W'(i);
            wr_en[i]  = !reset && !flush && (CNT_W'(i) < push_n);
        end
    end

    // NOTE: payload slots are deliberately not reset; out_valid alone qualifies them.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WAYS; i++) begin
            if (wr_en[i]) begin
                pkt_mem_q[wr_idx[i]] <= io.in_packet[i];
                prf_mem_q[wr_idx[i]] <= io.in_dest_prf[i];
                rob_mem_q[wr_idx[i]] <= io.in_rob_idx[i];
            end
        end
    end

    always_comb begin
        io.out_packet   = '0;
        io.out_dest_prf = '0;
        io.out_rob_idx  = '0;
        for (int i = 0; i < WAYS; i++) begin
            io.out_packet[i]   = pkt_mem_q[head + PTR_W'(i)];
            io.out_dest_prf[i] = prf_mem_q[head + PTR_W'(i)];
            io.out_rob_idx[i]  = rob_mem_q[head + PTR_W'(i)];
        end
    end

endmodule

// File: tb/tb_issue_fifo.sv
// Self-checking bench for issue_fifo: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_issue_fifo;
    import issue_fifo_pkg::*;

    localparam int TB_WAYS  = issue_fifo_pkg::WAYS;
    localparam int TB_DEPTH = issue_fifo_pkg::DEPTH;
    localparam int PRF_W    = $clog2(issue_fifo_pkg::PRF);
    localparam int ROB_W    = $clog2(issue_fifo_pkg::ROB);

    typedef struct {
        id_ex_packet_t    pkt;
        logic [PRF_W-1:0] prf;
        logic [ROB_W-1:0] rob;
    } entry_t;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    issue_fifo_if io ();

    issue_fifo dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .io    (io)
    );

    always #5 clock = ~clock;

    entry_t model_q[$];
    logic   model_ovf;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cycle    = 0;
    int     seq      = 100;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    endtask

    // Lane i carries sequence number seq+i; only valid lanes consume numbers.
    task automatic drive(input logic [TB_WAYS-1:0] valid, input logic [TB_WAYS-1:0] ready,
                         input logic fl);
        io.in_valid  = valid;
        io.out_ready = ready;
        flush        = fl;
        for (int i = 0; i < TB_WAYS; i++) begin
            io.in_packet[i].pc        = 32'(seq + i);
            io.in_packet[i].inst      = $urandom;
            io.in_packet[i].rs1_value = $urandom;
            io.in_packet[i].rs2_value = $urandom;
            io.in_dest_prf[i]         = PRF_W'(seq + i);
            io.in_rob_idx[i]          = ROB_W'(seq + i);
        end
        seq += $countones(valid);
    endtask

    task automatic compare_outputs();
        int                 sz;
        logic [TB_WAYS-1:0] exp_valid;
        sz        = model_q.size();
        exp_valid = '0;
        for (int i = 0; i < TB_WAYS; i++) exp_valid[i] = (i < sz);
        check("out_valid", 128'(io.out_valid), 128'(exp_valid));
        check("num_free", 128'(io.num_free), 128'(TB_DEPTH - sz));
        check("almost_full", 128'(io.almost_full), 128'((TB_DEPTH - sz) < TB_WAYS));
        check("overflow", 128'(io.overflow), 128'(model_ovf));
        for (int i = 0; i < TB_WAYS && i < sz; i++) begin
            check("lane_packet", 128'(io.out_packet[i]), 128'(model_q[i].pkt));
            check("lane_dest_prf", 128'(io.out_dest_prf[i]), 128'(model_q[i].prf));
            check("lane_rob_idx", 128'(io.out_rob_idx[i]), 128'(model_q[i].rob));
        end
    endtask

    // Compare the current outputs, clock once, then advance the model.
    task automatic step();
        int sz, pop_n, push_n, acc;
        compare_outputs();
        @(posedge clock);
        #1;
        cycle++;
        if (reset) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (flush) begin
            model_q.delete();
        end else begin
            sz    = model_q.size();
            pop_n = 0;
            for (int i = 0; i < TB_WAYS; i++) begin
                if (i < sz && io.out_ready[i]) pop_n++;
                else break;
            end
            push_n = $countones(io.in_valid);
            acc    = (push_n < TB_DEPTH - sz) ? push_n : TB_DEPTH - sz;
            if (push_n > acc) model_ovf = 1'b1;
            repeat (pop_n) void'(model_q.pop_front());
            for (int i = 0; i < acc; i++)
                model_q.push_back('{pkt: io.in_packet[i], prf: io.in_dest_prf[i],
                                    rob: io.in_rob_idx[i]});
        end
    endtask

    initial begin
        int n;
        logic [TB_WAYS-1:0] rv, rr;

        reset     = 1'b1;
        model_ovf = 1'b0;
        drive('0, '0, 1'b0);
        @(posedge clock);
        #1;
        check("reset_out_valid", 128'(io.out_valid), 128'(3'b000));
        check("reset_num_free", 128'(io.num_free), 128'(8));
        check("reset_almost_full", 128'(io.almost_full), 128'(0));
        check("reset_overflow", 128'(io.overflow), 128'(0));
        reset = 1'b0;

        // Three lanes in, visible one cycle later in lane order.
        drive(3'b111, 3'b000, 1'b0); step();
        check("push3_out_valid", 128'(io.out_valid), 128'(3'b111));
        check("push3_num_free", 128'(io.num_free), 128'(5));
        check("push3_lane0_pc", 128'(io.out_packet[0].pc), 128'(100));
        check("push3_lane1_pc", 128'(io.out_packet[1].pc), 128'(101));
        check("push3_lane2_pc", 128'(io.out_packet[2].pc), 128'(102));
        drive(3'b000, 3'b000, 1'b0); step();

        // Fill to DEPTH, then a further push is dropped.
        drive(3'b111, 3'b000, 1'b0); step();
        check("fill6_almost_full", 128'(io.almost_full), 128'(1));
        drive(3'b011, 3'b000, 1'b0); step();
        check("full_num_free", 128'(io.num_free), 128'(0));
        check("full_almost_full", 128'(io.almost_full), 128'(1));
        check("full_overflow_clear", 128'(io.overflow), 128'(0));
        drive(3'b001, 3'b000, 1'b0); step();
        check("drop_overflow", 128'(io.overflow), 128'(1));
        check("drop_num_free", 128'(io.num_free), 128'(0));
        check("drop_lane0_pc", 128'(io.out_packet[0].pc), 128'(100));

        // Drain to count=4, then ready=101 pops only lane 0.
        drive(3'b000, 3'b111, 1'b0); step();
        drive(3'b000, 3'b001, 1'b0); step();
        check("count4_num_free", 128'(io.num_free), 128'(4));
        drive(3'b000, 3'b101, 1'b0); step();
        check("gap_pop_num_free", 128'(io.num_free), 128'(5));
        check("gap_pop_lane0_pc", 128'(io.out_packet[0].pc), 128'(105));

        // head=6, count=2: pop 2 and push 3 across the wrap.
        drive(3'b000, 3'b001, 1'b0); step();
        check("head6_num_free", 128'(io.num_free), 128'(6));
        drive(3'b111, 3'b111, 1'b0); step();
        check("wrap_num_free", 128'(io.num_free), 128'(5));
        check("wrap_out_valid", 128'(io.out_valid), 128'(3'b111));
        check("wrap_lane0_pc", 128'(io.out_packet[0].pc), 128'(109));
        check("wrap_lane1_pc", 128'(io.out_packet[1].pc), 128'(110));
        check("wrap_lane2_pc", 128'(io.out_packet[2].pc), 128'(111));

        // count=5, push with flush in the same cycle.
        drive(3'b011, 3'b000, 1'b0); step();
        check("pre_flush_num_free", 128'(io.num_free), 128'(3));
        drive(3'b011, 3'b000, 1'b1); step();
        check("flush_out_valid", 128'(io.out_valid), 128'(3'b000));
        check("flush_num_free", 128'(io.num_free), 128'(8));
        check("flush_keeps_overflow", 128'(io.overflow), 128'(1));

        // Mid-operation reset with count=6 and overflow set.
        drive(3'b111, 3'b000, 1'b0); step();
        drive(3'b111, 3'b000, 1'b0); step();
        check("pre_reset_num_free", 128'(io.num_free), 128'(2));
        reset = 1'b1;
        drive(3'b111, 3'b111, 1'b1); step();
        check("rst_out_valid", 128'(io.out_valid), 128'(3'b000));
        check("rst_num_free", 128'(io.num_free), 128'(8));
        check("rst_almost_full", 128'(io.almost_full), 128'(0));
        check("rst_overflow", 128'(io.overflow), 128'(0));
        reset = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            n  = $urandom_range(0, TB_WAYS);
            rv = TB_WAYS'((1 << n) - 1);
            rr = TB_WAYS'($urandom);
            drive(rv, rr, ($urandom_range(0, 49) == 0));
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        drive('0, '0, 1'b0);
        step();
        compare_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
